writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, at least 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have ports ld_valid input 1, ld_ready output 1, ld_rd input 5, ld_data input 32: load-unit result channel.
REQ-005 SHALL have ports alu_valid input 1, alu_ready output 1, alu_rd input 5, alu_data input 32: ALU result channel.
REQ-006 SHALL have port WE3, output, 1, register-file write enable.
REQ-007 SHALL have port AD3, output, 5, register-file write address.
REQ-008 SHALL have port WD3, output, 32, register-file write data.
REQ-009 SHALL have port busy, output, 1, high when any accepted result is not yet written.
REQ-010 SHALL have ports chk_ad input 5, chk_hit output 1, chk_data output 32: pending-write lookup (see Configuration).

Function
REQ-011 SHALL transfer a channel transaction on a rising edge where its valid and ready are both high.
REQ-012 SHALL drive ld_ready = (count <= DEPTH-1) and alu_ready = (count <= DEPTH-2), where count is the registered queue occupancy; neither ready depends on any valid.
REQ-013 SHALL accept both channels in the same cycle when both handshakes occur; the load entry is enqueued ahead of the ALU entry.
REQ-014 SHALL accept but discard any transaction with rd = 0; it occupies no queue slot and produces no write.
REQ-015 SHALL, on every edge where count > 0, pop the head entry into the WE3/AD3/WD3 output register with WE3 = 1; otherwise it SHALL load WE3 = 0 and hold AD3/WD3.
REQ-016 SHALL give 2-cycle latency: an entry accepted into an empty queue at edge N drives WE3 = 1 during the cycle after edge N+1.
REQ-017 SHALL perform at most one register write per cycle and preserve acceptance order, so a later write to the same rd overwrites an earlier one.
REQ-018 SHALL update count as count + enqueues - pop on each edge, with read/write pointers wrapping modulo DEPTH.
REQ-019 SHALL never overflow: enqueue at count = DEPTH-1 with a simultaneous pop is legal; alu_ready is low at count = DEPTH-1.
REQ-020 SHALL drive busy = (count != 0) | WE3.

Reset
REQ-021 SHALL on rst clear count and both pointers and set WE3 = 0, AD3 = 0, WD3 = 0, overriding any same-cycle handshake or pop.
REQ-022 SHALL discard all queued entries when reset is asserted mid-operation; no write from a discarded entry appears afterwards.
REQ-023 SHALL present ld_ready = 1, alu_ready = 1, busy = 0 and chk_hit = 0 in the first cycle after reset.

Configuration
REQ-024 SHALL honour macro WB_FORWARD_EN.
REQ-025 With WB_FORWARD_EN defined, chk_hit/chk_data SHALL be combinational:
  - match on the youngest valid queue entry with rd = chk_ad, else the output register when WE3 = 1 and AD3 = chk_ad;
  - chk_hit = 1 and chk_data = that entry's data;
  - chk_ad = 0 SHALL never hit.
REQ-026 Without WB_FORWARD_EN, chk_hit and chk_data SHALL be tied to 0 and chk_ad ignored.

Verification
REQ-027 Single load: ld rd=5 data=0xDEADBEEF accepted at edge 1 -> WE3=1 AD3=5 WD3=0xDEADBEEF in the cycle after edge 2 only; busy low afterwards.
REQ-028 Same-cycle dual: ld rd=3 data=0x11, alu rd=3 data=0x22 -> two consecutive writes, 0x11 then 0x22.
REQ-029 x0 drop: alu rd=0 data=0xFFFFFFFF accepted -> WE3 stays 0, count stays 0, busy stays 0.
REQ-030 Fill (DEPTH=4): both channels valid every cycle -> alu_ready falls at count=3, no entry lost, writes in order, one per cycle.
REQ-031 Reset mid-stream: rst with count=3 -> next cycle WE3=0, busy=0, and none of the 3 queued writes ever appears.
REQ-032 Forwarding (WB_FORWARD_EN): queue rd=7 data=0xA then rd=7 data=0xB, chk_ad=7 -> chk_hit=1, chk_data=0xB; chk_ad=0 -> chk_hit=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Merges load-unit and ALU results through an in-order queue into one register-file write port.
// Optional pending-write lookup on chk_ad/chk_hit/chk_data is enabled by the WB_FORWARD_EN macro.
module writeback_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        WE3,
   output logic [4:0]  AD3,
   output logic [31:0] WD3,
   output logic        busy,
   input  logic [4:0]  chk_ad,
   output logic        chk_hit,
   output logic [31:0] chk_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE     = PW'(1);
   localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
   localparam logic [CW-1:0] CNT_LD_MAX  = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ALU_MAX = CW'(DEPTH - 2);

   logic [4:0]    rd_mem_q   [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] alu_idx_s;
   logic [CW-1:0] count_q, count_d;
   logic          ld_en_s, alu_en_s, pop_s;
   logic          we3_q, we3_d;
   logic [4:0]    ad3_q, ad3_d;
   logic [31:0]   wd3_q, wd3_d;
   logic          ld_ready_q, alu_ready_q, busy_q;

   // Next-state: accepted enqueues (rd=0 dropped), head pop, pointer/count update, output load.
   always_comb begin
      ld_en_s   = ld_valid & ld_ready_q & (ld_rd != 5'd0);
      alu_en_s  = alu_valid & alu_ready_q & (alu_rd != 5'd0);
      pop_s     = (count_q != CNT_ZERO);
      alu_idx_s = ld_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      wr_ptr_d  = alu_en_s ? (alu_idx_s + PTR_ONE) : alu_idx_s;
      rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      count_d   = count_q + {{PW{1'b0}}, ld_en_s} + {{PW{1'b0}}, alu_en_s}
                  - {{PW{1'b0}}, pop_s};
      we3_d     = 1'b0;
      ad3_d     = ad3_q;
      wd3_d     = wd3_q;
      if (pop_s) begin
         we3_d = 1'b1;
         ad3_d = rd_mem_q[rd_ptr_q];
         wd3_d = data_mem_q[rd_ptr_q];
      end else begin
         we3_d = 1'b0;
      end
   end

   // Control/output registers; readies and busy are precomputed from next-state occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         we3_q       <= 1'b0;
         ad3_q       <= 5'd0;
         wd3_q       <= 32'd0;
         ld_ready_q  <= 1'b1;
         alu_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         we3_q       <= we3_d;
         ad3_q       <= ad3_d;
         wd3_q       <= wd3_d;
         ld_ready_q  <= (count_d <= CNT_LD_MAX);
         alu_ready_q <= (count_d <= CNT_ALU_MAX);
         busy_q      <= (count_d != CNT_ZERO) | we3_d;
      end
   end

   // Queue storage; the load entry lands ahead of a same-cycle ALU entry.
   always_ff @(posedge clk) begin
      if (ld_en_s) begin
         rd_mem_q[wr_ptr_q]   <= ld_rd;
         data_mem_q[wr_ptr_q] <= ld_data;
      end
      if (alu_en_s) begin
         rd_mem_q[alu_idx_s]   <= alu_rd;
         data_mem_q[alu_idx_s] <= alu_data;
      end
   end

`ifdef WB_FORWARD_EN
   logic [PW-1:0] fwd_idx_s;
   logic          fwd_match_s;

   // Lookup: output register first, then queue oldest-to-youngest so the youngest match wins.
   always_comb begin
      chk_hit     = 1'b0;
      chk_data    = 32'd0;
      fwd_idx_s   = rd_ptr_q;
      fwd_match_s = we3_q & (ad3_q == chk_ad) & (chk_ad != 5'd0);
      chk_hit     = fwd_match_s;
      chk_data    = fwd_match_s ? wd3_q : 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx_s   = rd_ptr_q + PW'(i);
         fwd_match_s = (CW'(i) < count_q) & (rd_mem_q[fwd_idx_s] == chk_ad)
                       & (chk_ad != 5'd0);
         chk_hit     = fwd_match_s ? 1'b1 : chk_hit;
         chk_data    = fwd_match_s ? data_mem_q[fwd_idx_s] : chk_data;
      end
   end
`else
   logic unused_chk_s;

   // Lookup disabled: outputs tied low and chk_ad intentionally ignored.
   always_comb begin
      unused_chk_s = ^chk_ad;
      chk_hit      = 1'b0;
      chk_data     = 32'd0;
   end
`endif

   assign ld_ready  = ld_ready_q;
   assign alu_ready = alu_ready_q;
   assign WE3       = we3_q;
   assign AD3       = ad3_q;
   assign WD3       = wd3_q;
   assign busy      = busy_q;

endmodule
